pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor and the next generation of the 4-bit group lookahead unit. Operands are split into BLOCK-bit lookahead groups. Each group computes per-bit carries plus group generate/propagate, and groups are chained through the carry. The group chain is cut into STAGES register stages with per-stage valid/ready flow control, which allows full throughput with backpressure. The block sits in the datapath as the wide integer add/sub unit.

---
 rtl/pipelined_cla_adder.sv | 189 ++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//   Wide integer add/sub built from BLOCK-bit carry-lookahead groups. The
//   group chain is cut into STAGES register stages; each stage resolves
//   WIDTH/STAGES result bits and carries the remaining operand bits, the
//   running carry and the running word generate/propagate to the next
//   stage. Per-stage valid/ready gives full throughput under backpressure.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   in_valid / in_ready   operand beat handshake
//   a, b, c_in, sub       operands; sub=1 computes a-b (c_in ignored)
//   out_valid / out_ready result handshake
//   sum, c_out            result and carry out of the MSB (sub: 1 = no borrow)
//   ovf                   signed overflow (carry into MSB ^ carry out)
//   grp_g, grp_p          whole-word generate / propagate
// ---------------------------------------------------------------------------

// One pipeline slice: SW/BLOCK lookahead groups chained through the carry.
// Also folds the slice's group G/P into the running word G/P.
module cla_slice #(
  parameter int SW    = 16,
  parameter int BLOCK = 4
) (
  input  logic [SW-1:0] a_i,
  input  logic [SW-1:0] bx_i,
  input  logic          c_i,
  input  logic          g_i,
  input  logic          p_i,
  output logic [SW-1:0] s_o,
  output logic          c_o,
  output logic          g_o,
  output logic          p_o
);
  logic [SW-1:0] g, p;
  logic cb, gg, gp, c_run, g_run, p_run;

  assign g = a_i & bx_i;
  assign p = a_i ^ bx_i;

  always_comb begin
    s_o   = '0;
    cb    = 1'b0;
    gg    = 1'b0;
    gp    = 1'b1;
    c_run = c_i;
    g_run = g_i;
    p_run = p_i;
    for (int n = 0; n < SW/BLOCK; n++) begin
      cb = c_run;
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
        s_o[n*BLOCK+j] = p[n*BLOCK+j] ^ cb;
        cb = g[n*BLOCK+j] | (p[n*BLOCK+j] & cb);
        // Accumulating from bit 0 upward yields g3|p3g2|p3p2g1|p3p2p1g0.
        gg = g[n*BLOCK+j] | (p[n*BLOCK+j] & gg);
        gp = gp & p[n*BLOCK+j];
      end
      // Group carry-out in lookahead form; upper group is the "hi" operand
      // of the word G/P combine.
      c_run = gg | (gp & c_run);
      g_run = gg | (gp & g_run);
      p_run = p_run & gp;
    end
    c_o = c_run;
    g_o = g_run;
    p_o = p_run;
  end
endmodule

module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             grp_g,
  output logic             grp_p
);
  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0] vld;
  logic [STAGES:0]   adv;   // adv[k]: stage k loads this cycle
  logic              cm_q;  // carry into MSB

  // Ready chain walks from the output back to the input in one pass.
  always_comb begin
    adv         = '0;
    adv[STAGES] = vld[STAGES-1] & out_ready;
    for (int k = STAGES-1; k >= 0; k--) begin
      if (k == 0) adv[k] = in_valid & (~vld[k] | adv[k+1]);
      else        adv[k] = vld[k-1] & (~vld[k] | adv[k+1]);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int REMW = WIDTH - k*SW;  // operand bits not yet summed
    logic [REMW-1:0]       a_v, bx_v;
    logic                  cin_v, gin_v, pin_v;
    logic [SW-1:0]         s_sl;
    logic                  c_sl, g_sl, p_sl;
    logic [(k+1)*SW-1:0]   s_d, s_q;
    logic                  c_q, g_q, p_q, vld_q;

    if (k == 0) begin : g_head
      assign a_v   = a;
      assign bx_v  = sub ? ~b : b;
      assign cin_v = sub | c_in;
      assign gin_v = 1'b0;
      assign pin_v = 1'b1;
      assign s_d   = s_sl;
    end else begin : g_body
      // Remaining operand bits travel with the beat, loaded with stage k-1.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_v  <= '0;
          bx_v <= '0;
        end else if (adv[k-1]) begin
          a_v  <= g_stg[k-1].a_v[REMW+SW-1:SW];
          bx_v <= g_stg[k-1].bx_v[REMW+SW-1:SW];
        end
      end
      assign cin_v = g_stg[k-1].c_q;
      assign gin_v = g_stg[k-1].g_q;
      assign pin_v = g_stg[k-1].p_q;
      assign s_d   = {s_sl, g_stg[k-1].s_q};
    end

    cla_slice #(.SW(SW), .BLOCK(BLOCK)) u_slice (
      .a_i (a_v[SW-1:0]),
      .bx_i(bx_v[SW-1:0]),
      .c_i (cin_v),
      .g_i (gin_v),
      .p_i (pin_v),
      .s_o (s_sl),
      .c_o (c_sl),
      .g_o (g_sl),
      .p_o (p_sl)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q   <= '0;
        c_q   <= 1'b0;
        g_q   <= 1'b0;
        p_q   <= 1'b0;
        vld_q <= 1'b0;
      end else begin
        if (adv[k]) begin
          s_q <= s_d;
          c_q <= c_sl;
          g_q <= g_sl;
          p_q <= p_sl;
        end
        vld_q <= adv[k] | (vld_q & ~adv[k+1]);
      end
    end
    assign vld[k] = vld_q;

    if (k == STAGES-1) begin : g_tail
      // Carry into the MSB recovered from the MSB sum bit: s = p ^ c.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         cm_q <= 1'b0;
        else if (adv[k]) cm_q <= s_sl[SW-1] ^ a_v[SW-1] ^ bx_v[SW-1];
      end
    end
  end

  assign in_ready  = ~vld[0] | adv[1];
  assign out_valid = vld[STAGES-1];
  assign sum       = g_stg[STAGES-1].s_q;
  assign c_out     = g_stg[STAGES-1].c_q;
  assign grp_g     = g_stg[STAGES-1].g_q;
  assign grp_p     = g_stg[STAGES-1].p_q;
  assign ovf       = cm_q ^ g_stg[STAGES-1].c_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;
  localparam int W = 32;
  localparam int STAGES = 2;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic c_in = 1'b0, sub = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic [W-1:0] sum;
  logic c_out, ovf, grp_g, grp_p;

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(4), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf),
    .grp_g(grp_g), .grp_p(grp_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic co, ov, gg, gp, lat;
    int cyc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic hold_chk = 1'b0;
  logic [W-1:0] held_sum;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain wide arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] av, bv, input logic ci, sb);
    exp_t e;
    logic [W-1:0] bx;
    logic [W:0] t, t0;
    logic cc;
    longint sv;
    bx = sb ? ~bv : bv;
    cc = sb ? 1'b1 : ci;
    t  = {1'b0, av} + {1'b0, bx} + {{W{1'b0}}, cc};
    t0 = {1'b0, av} + {1'b0, bx};
    sv = longint'($signed(av)) + longint'($signed(bx)) + longint'(cc);
    e.s  = t[W-1:0];
    e.co = t[W];
    e.ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    e.gg = t0[W];          // word generate = carry out with zero carry-in
    e.gp = &(av ^ bx);
    e.lat = 1'b0;
    e.cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: pops and compares whenever a result is taken.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (hold_chk) begin
        n_chk++;
        if (!out_valid || sum !== held_sum) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%b sum=%h expected valid=1 sum=%h", out_valid, sum, held_sum);
        end
      end
      hold_chk = out_valid && !out_ready;
      held_sum = sum;
      if (out_valid && out_ready) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: sum=%h with empty scoreboard", sum);
        end else begin
          e = q.pop_front();
          if ({sum, c_out, ovf, grp_g, grp_p} !== {e.s, e.co, e.ov, e.gg, e.gp}) begin
            n_fail++;
            $display("FAIL result: sum=%h co=%b ovf=%b g=%b p=%b expected sum=%h co=%b ovf=%b g=%b p=%b",
                     sum, c_out, ovf, grp_g, grp_p, e.s, e.co, e.ov, e.gg, e.gp);
          end
          if (e.lat) begin
            n_chk++;
            if (cyc - e.cyc != STAGES) begin
              n_fail++;
              $display("FAIL latency: got %0d expected %0d", cyc - e.cyc, STAGES);
            end
          end
        end
      end
    end else hold_chk = 1'b0;
  end

  task automatic send(input logic [W-1:0] av, bv, input logic ci, sb,
                      input logic lat, output int stalls);
    exp_t e;
    logic acc;
    acc = 1'b0;
    stalls = 0;
    in_valid = 1'b1; a = av; b = bv; c_in = ci; sub = sb;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e = model(av, bv, ci, sb);
        e.lat = lat;
        e.cyc = cyc;
        q.push_back(e);
        acc = 1'b1;
      end else stalls++;
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
    end
  endtask

  task automatic idle_drain();
    in_valid = 1'b0;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int st, cnt;
    logic [W-1:0] ra, rb;
    // Reset state
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", {27'd0, sum, c_out, ovf, grp_g, grp_p}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Directed boundary cases, back to back, latency checked
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, st);
    send(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b1, st);
    send(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, st);
    send(32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 1'b1, st);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, st);
    send(32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b1, st);
    idle_drain();

    // Streaming: in_ready must never drop
    for (int i = 0; i < 16; i++) begin
      send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1, st);
      check("stream_no_stall", 64'(st), 64'd0);
    end
    idle_drain();

    // Backpressure: only STAGES beats fit
    out_ready = 1'b0;
    in_valid = 1'b1;
    ra = $urandom; rb = $urandom;
    a = ra; b = rb; c_in = 1'($urandom); sub = 1'($urandom);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(a, b, c_in, sub));
        cnt++;
        @(posedge clk); #1;
        a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
      end else begin
        @(posedge clk); #1;
      end
    end
    check("bp_accepted", 64'(cnt), 64'(STAGES));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(a, b, c_in, sub, 1'b0, st);
    for (int i = 0; i < 4; i++) send($urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0, st);
    idle_drain();

    // Reset with two beats in flight
    send($urandom, $urandom, 1'b0, 1'b0, 1'b0, st);
    send($urandom, $urandom, 1'b1, 1'b0, 1'b0, st);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    q.delete();
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_outputs", {27'd0, sum, c_out, ovf, grp_g, grp_p}, 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_out_valid", 64'(out_valid), 64'd0);
    send(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 1'b1, st);
    idle_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
